// File: rtl/pkt_pkg.sv
// -----------------------------------------------------------------------------
// pkt_pkg
// Shared constants and types for the packet CRC framer:
//   PAYLOAD_BYTES / CRC_BYTES / FRAME_BYTES : frame geometry (32 + 4 bytes)
//   CNT_W                                   : width of the in-frame byte counter
//   payload_t / crc_t                       : 256-bit payload, 32-bit CRC
//   framer_state_e                          : framer FSM states
// -----------------------------------------------------------------------------
package pkt_pkg;

  localparam int PAYLOAD_BYTES = 32;
  localparam int CRC_BYTES     = 4;
  localparam int FRAME_BYTES   = PAYLOAD_BYTES + CRC_BYTES;
  localparam int CNT_W         = $clog2(FRAME_BYTES);

  typedef logic [8*PAYLOAD_BYTES-1:0] payload_t;
  typedef logic [8*CRC_BYTES-1:0]     crc_t;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_DRAIN,
    ST_ISSUE,
    ST_WAIT_CRC,
    ST_OUTPUT
  } framer_state_e;

endpackage

// File: rtl/pkt_crc_framer_if.sv
// -----------------------------------------------------------------------------
// pkt_crc_framer_if
// Bundles the framer's byte-stream input, the side channel to the external crc
// block, and the packet output towards the downstream FIFO.
//   slave  : framer side (consumes bytes and crc results, produces packets)
//   master : environment side (byte source, crc block, packet FIFO)
// Signals:
//   in_valid/in_data/in_last/in_ready : byte stream handshake
//   crc_valid/crc_data                : payload handed to crc
//   crc_result/crc_done               : computed CRC back from crc
//   pkt_valid/pkt_data/pkt_ok/pkt_ready : packet to FIFO with pass/fail flag
//   err_len/err_timeout               : one-cycle error pulses
//   bad_cnt                           : saturating CRC-failure count
// -----------------------------------------------------------------------------
interface pkt_crc_framer_if;
  import pkt_pkg::*;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;

  logic        crc_valid;
  payload_t    crc_data;
  crc_t        crc_result;
  logic        crc_done;

  logic        pkt_valid;
  payload_t    pkt_data;
  logic        pkt_ok;
  logic        pkt_ready;

  logic        err_len;
  logic        err_timeout;
  logic [15:0] bad_cnt;

  modport slave (
    input  in_valid, in_data, in_last, crc_result, crc_done, pkt_ready,
    output in_ready, crc_valid, crc_data, pkt_valid, pkt_data, pkt_ok,
           err_len, err_timeout, bad_cnt
  );

  modport master (
    output in_valid, in_data, in_last, crc_result, crc_done, pkt_ready,
    input  in_ready, crc_valid, crc_data, pkt_valid, pkt_data, pkt_ok,
           err_len, err_timeout, bad_cnt
  );

endinterface

// File: rtl/pkt_byte_shifter.sv
// -----------------------------------------------------------------------------
// pkt_byte_shifter
// Byte counter plus a 288-bit shift register holding payload and trailer.
// Bytes enter at the LSB end, so after 36 loads the first byte sits in the MSB.
// Ports:
//   clk, rst   : clock, async active-high reset
//   clear      : reset the byte count (data is kept so the payload survives)
//   load_byte  : shift din in and advance the count
//   din        : incoming byte
//   count      : bytes collected in the current frame
//   payload    : bytes 0..31, byte 0 in [255:248]
//   rx_crc     : bytes 32..35, byte 32 in [31:24]
// -----------------------------------------------------------------------------
module pkt_byte_shifter
  import pkt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load_byte,
  input  logic [7:0]       din,
  output logic [CNT_W-1:0] count,
  output payload_t         payload,
  output crc_t             rx_crc
);

  localparam int SR_W = 8 * FRAME_BYTES;

  logic [SR_W-1:0] sr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the data register is reset (not left as don't-care) because it
  // drives crc_data/pkt_data directly and those must read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr    <= '0;
      count <= '0;
    end else begin
      if (load_byte) sr <= {sr[SR_W-9:0], din};
      if (clear)          count <= '0;
      else if (load_byte) count <= count + 1'b1;
    end
  end

  assign payload = sr[SR_W-1 -: 8*PAYLOAD_BYTES];
  assign rx_crc  = sr[8*CRC_BYTES-1:0];

endmodule

// File: rtl/pkt_crc_framer.sv
// -----------------------------------------------------------------------------
// pkt_crc_framer
// Collects 32 payload bytes + 4-byte big-endian CRC trailer, hands the payload
// to an external crc block, compares its result against the trailer and
// presents the payload with a pass/fail flag to the packet FIFO.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset
//   bus   : pkt_crc_framer_if.slave (byte stream, crc channel, packet out,
//           error pulses, bad_cnt)
// Parameter:
//   TIMEOUT : cycles to wait for crc_done before dropping the packet
// Build option:
//   PKT_CRC_DROP_BAD_EN : when defined, packets failing the CRC compare are
//                         dropped instead of being presented with pkt_ok=0.
// -----------------------------------------------------------------------------
module pkt_crc_framer
  import pkt_pkg::*;
#(
  parameter int TIMEOUT = 64
)
(
  input  logic            clk,
  input  logic            rst,
  pkt_crc_framer_if.slave bus
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  framer_state_e    state;
  logic             in_ready_q;
  logic             crc_valid_q;
  logic             pkt_valid_q;
  logic             pkt_ok_q;
  logic             err_len_q;
  logic             err_timeout_q;
  logic [15:0]      bad_cnt_q;
  logic [TMO_W-1:0] tmo_cnt;

  logic             accept;
  logic             load_byte;
  logic             clear;
  logic             full;
  logic             crc_match;
  logic [CNT_W-1:0] count;
  payload_t         payload;
  crc_t             rx_crc;

  assign accept    = bus.in_valid && in_ready_q;
  assign load_byte = accept && (state == ST_COLLECT);
  // Any frame end (good, short, or overlong) restarts the count; the shifted
  // data itself is kept so a good payload stays visible on crc_data/pkt_data.
  assign clear     = load_byte && (bus.in_last || full);
  assign full      = (count == CNT_W'(FRAME_BYTES - 1));
  assign crc_match = (bus.crc_result == rx_crc);

  pkt_byte_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .load_byte (load_byte),
    .din       (bus.in_data),
    .count     (count),
    .payload   (payload),
    .rx_crc    (rx_crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_COLLECT;
      in_ready_q    <= 1'b0;
      crc_valid_q   <= 1'b0;
      pkt_valid_q   <= 1'b0;
      pkt_ok_q      <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      bad_cnt_q     <= '0;
      tmo_cnt       <= '0;
    end else begin
      crc_valid_q   <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;

      case (state)
        ST_COLLECT: begin
          in_ready_q <= 1'b1;
          if (load_byte) begin
            if (bus.in_last && full) begin
              state       <= ST_ISSUE;
              crc_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else if (bus.in_last) begin
              err_len_q <= 1'b1;
            end else if (full) begin
              err_len_q <= 1'b1;
              state     <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          in_ready_q <= 1'b1;
          if (accept && bus.in_last) state <= ST_COLLECT;
        end

        ST_ISSUE: begin
          state   <= ST_WAIT_CRC;
          tmo_cnt <= '0;
        end

        ST_WAIT_CRC: begin
          if (bus.crc_done) begin
            pkt_ok_q <= crc_match;
            if (!crc_match && (bad_cnt_q != 16'hFFFF)) bad_cnt_q <= bad_cnt_q + 1'b1;
`ifdef PKT_CRC_DROP_BAD_EN
            if (crc_match) begin
              state       <= ST_OUTPUT;
              pkt_valid_q <= 1'b1;
            end else begin
              state      <= ST_COLLECT;
              in_ready_q <= 1'b1;
            end
`else
            state       <= ST_OUTPUT;
            pkt_valid_q <= 1'b1;
`endif
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            err_timeout_q <= 1'b1;
            state         <= ST_COLLECT;
            in_ready_q    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_OUTPUT: begin
          if (bus.pkt_ready) begin
            pkt_valid_q <= 1'b0;
            state       <= ST_COLLECT;
            in_ready_q  <= 1'b1;
          end
        end

        default: state <= ST_COLLECT;
      endcase
    end
  end

  // The shift register is frozen outside COLLECT, so it doubles as the
  // stable crc_data/pkt_data hold register.
  assign bus.in_ready    = in_ready_q;
  assign bus.crc_valid   = crc_valid_q;
  assign bus.crc_data    = payload;
  assign bus.pkt_valid   = pkt_valid_q;
  assign bus.pkt_data    = payload;
  assign bus.pkt_ok      = pkt_ok_q;
  assign bus.err_len     = err_len_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.bad_cnt     = bad_cnt_q;

endmodule

// File: tb/tb_pkt_crc_framer.sv
// -----------------------------------------------------------------------------
// tb_pkt_crc_framer
// Self-checking bench for pkt_crc_framer. The bench plays the byte source, the
// crc block (a bitwise CRC-32 over the 32 payload bytes) and the packet FIFO.
// Honours PKT_CRC_DROP_BAD_EN when compiled with the same define as the RTL.
// -----------------------------------------------------------------------------
module tb_pkt_crc_framer;
  import pkt_pkg::*;

  logic clk = 1'b0;
  logic rst;

  pkt_crc_framer_if bus ();

  pkt_crc_framer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_bad = '0;
  logic        drop_bad;

  // CRC-32 (poly 04C11DB7, init all-ones, final invert) over payload bytes in
  // transmission order: this is the bench's model of the external crc block.
  function automatic crc_t ref_crc(input payload_t p);
    crc_t       c = 32'hFFFF_FFFF;
    logic [7:0] b;
    for (int k = 0; k < PAYLOAD_BYTES; k++) begin
      b = p[255 - 8*k -: 8];
      c = c ^ {b, 24'h0};
      for (int i = 0; i < 8; i++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
    end
    return ~c;
  endfunction

  task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All bench actions happen 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int budget = 0;
    if ($urandom_range(0, 3) == 0) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_last  = last;
    while (!bus.in_ready && budget < 200) begin
      tick();
      budget++;
    end
    if (budget >= 200) check("in_ready_wait", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Sends a full 36-byte frame and plays crc/FIFO. lat < 1 means crc never
  // answers (timeout path).
  task automatic run_frame(input string tag, input payload_t p, input crc_t trailer,
                           input int lat, input int hold);
    logic [7:0] fb [FRAME_BYTES];
    logic       exp_ok;
    int         seen;
    for (int k = 0; k < PAYLOAD_BYTES; k++) fb[k] = p[255 - 8*k -: 8];
    for (int k = 0; k < CRC_BYTES; k++) fb[PAYLOAD_BYTES + k] = trailer[31 - 8*k -: 8];
    for (int k = 0; k < FRAME_BYTES; k++) send_byte(fb[k], k == FRAME_BYTES - 1);

    check({tag, ".issue"}, {bus.crc_valid, bus.in_ready, bus.crc_data}, {1'b1, 1'b0, p});
    tick();
    check({tag, ".crc_valid_1cyc"}, bus.crc_valid, 1'b0);

    if (lat < 1) begin
      seen = 0;
      for (int j = 1; j <= 100; j++) begin
        if (j > 1) check({tag, ".wait_hold"}, {bus.crc_data, bus.in_ready}, {p, 1'b0});
        tick();
        if (bus.err_timeout) begin
          seen = j;
          break;
        end
      end
      check({tag, ".timeout_cycle"}, seen, 64);
      check({tag, ".timeout_ready"}, {bus.in_ready, bus.pkt_valid}, {1'b1, 1'b0});
      tick();
      check({tag, ".timeout_pulse"}, bus.err_timeout, 1'b0);
      return;
    end

    repeat (lat - 1) tick();
    check({tag, ".wait_ready"}, bus.in_ready, 1'b0);
    bus.crc_result = ref_crc(bus.crc_data);
    bus.crc_done   = 1'b1;
    tick();
    bus.crc_done   = 1'b0;
    bus.crc_result = $urandom;

    exp_ok = (trailer == ref_crc(p));
    if (!exp_ok && exp_bad != 16'hFFFF) exp_bad++;
    check({tag, ".bad_cnt"}, bus.bad_cnt, exp_bad);

    if (!exp_ok && drop_bad) begin
      check({tag, ".dropped"}, {bus.pkt_valid, bus.in_ready}, {1'b0, 1'b1});
      return;
    end

    check({tag, ".pkt"}, {bus.pkt_valid, bus.pkt_ok, bus.pkt_data}, {1'b1, exp_ok, p});
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, ".backpressure"}, {bus.pkt_valid, bus.in_ready, bus.pkt_ok, bus.pkt_data},
            {1'b1, 1'b0, exp_ok, p});
    end
    bus.pkt_ready = 1'b1;
    tick();
    bus.pkt_ready = 1'b0;
    check({tag, ".released"}, {bus.pkt_valid, bus.in_ready}, {1'b0, 1'b1});
  endtask

  initial begin
    payload_t p_gold;
    payload_t p_a5;
    payload_t p;
    crc_t     tr;

`ifdef PKT_CRC_DROP_BAD_EN
    drop_bad = 1'b1;
`else
    drop_bad = 1'b0;
`endif
    p_gold = 256'h0123456789ABCDEF00112233445566778899AABBCCDDEEFF0F1E2D3C4B5A6978;
    p_a5   = {40'hA5DEADBEEF, {25{8'h5A}}, 16'hDAAA};

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.crc_result = '0;
    bus.crc_done   = 1'b0;
    bus.pkt_ready  = 1'b0;

    // Reset values
    repeat (2) tick();
    check("reset.flags", {bus.in_ready, bus.crc_valid, bus.pkt_valid, bus.pkt_ok,
                          bus.err_len, bus.err_timeout}, 6'b0);
    check("reset.crc_data", bus.crc_data, '0);
    check("reset.pkt_data", bus.pkt_data, '0);
    check("reset.bad_cnt", bus.bad_cnt, 16'h0);
    rst = 1'b0;
    tick();
    check("reset.in_ready_after", bus.in_ready, 1'b1);

    // crc_done outside WAIT_CRC has no effect
    bus.crc_result = 32'hDEAD_BEEF;
    bus.crc_done   = 1'b1;
    tick();
    bus.crc_done   = 1'b0;
    check("stray_done", {bus.pkt_valid, bus.in_ready, bus.bad_cnt}, {1'b0, 1'b1, 16'h0});

    // Golden frame, then corrupted trailer
    run_frame("good", p_gold, ref_crc(p_gold), 1, 0);
    run_frame("corrupt", p_gold, ref_crc(p_gold) ^ 32'h1, 2, 0);

    // Short frame: in_last on byte 10
    for (int k = 0; k <= 10; k++) begin
      send_byte(8'(k * 7), k == 10);
      if (k < 10) check("short.no_err", {bus.err_len, bus.crc_valid}, 2'b00);
    end
    check("short.err_len", {bus.err_len, bus.crc_valid, bus.in_ready}, 3'b101);
    tick();
    check("short.pulse", {bus.err_len, bus.crc_valid, bus.in_ready}, 3'b001);
    run_frame("after_short", p_a5, ref_crc(p_a5), 1, 0);

    // Long frame: 40 bytes, in_last on byte 39
    for (int k = 0; k < 40; k++) begin
      send_byte(8'($urandom), k == 39);
      if (k == 35) check("long.err_len", {bus.err_len, bus.in_ready}, 2'b11);
      else         check("long.no_err", {bus.err_len, bus.crc_valid}, 2'b00);
    end
    check("long.drained", {bus.in_ready, bus.crc_valid}, 2'b10);
    run_frame("after_long", p_gold, ref_crc(p_gold), 1, 0);

    // Backpressure
    run_frame("backpressure", p_a5, ref_crc(p_a5), 1, 5);

    // Reset mid-frame
    for (int k = 0; k < 12; k++) send_byte(8'($urandom), 1'b0);
    rst = 1'b1;
    #1;
    check("midreset.async", {bus.in_ready, bus.bad_cnt}, {1'b0, 16'h0});
    exp_bad = '0;
    tick();
    rst = 1'b0;
    tick();
    check("midreset.ready", bus.in_ready, 1'b1);
    run_frame("after_reset", p_gold, ref_crc(p_gold), 1, 0);

    // Timeout
    run_frame("timeout", p_a5, ref_crc(p_a5), 0, 0);
    run_frame("after_timeout", p_gold, ref_crc(p_gold), 3, 1);

    // Randomized frames
    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < 8; w++) p[32*w +: 32] = $urandom;
      tr = ref_crc(p);
      if ($urandom_range(0, 2) == 0) tr = tr ^ (32'h1 << $urandom_range(0, 31));
      run_frame("random", p, tr, $urandom_range(1, 6), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
